// File: rtl/mult_fu_pkg.sv
// mult_fu_pkg: types shared by the multiply functional unit, its interface and the issue/complete stages.
// Build option MULT_HIGH_EN: defined -> MULH/MULHSU/MULHU supported, 64-bit accumulator;
// undefined -> MUL only, 32-bit accumulator, operands zero-extended.
package mult_fu_pkg;

    // Pipeline depth; must divide 64.
    localparam int DEFAULT_MULT_STAGES = 4;

    typedef logic [31:0] DATA;
    typedef logic [5:0]  PHYS_REG_IDX;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        logic        valid;
        DATA         source_reg_1;
        DATA         source_reg_2;
        MULT_FUNC    func;
        PHYS_REG_IDX dest_reg_idx;
    } MULT_PACKET;

`ifdef MULT_HIGH_EN
    localparam int ACC_W = 64;
`else
    localparam int ACC_W = 32;
`endif

    typedef logic [ACC_W-1:0] acc_t;

    // One pipeline slot: the op's identity plus its partially folded product.
    typedef struct packed {
        logic        valid;
        MULT_FUNC    func;
        PHYS_REG_IDX dest;
        acc_t        mcand;
        acc_t        mplier;
        acc_t        acc;
    } stage_t;

endpackage

// File: rtl/mult_fu_if.sv
// mult_fu_if: issue-side packet/free handshake and complete-side CDB request/grant.
// master = issue + complete logic, slave = the multiply FU.
interface mult_fu_if;
    import mult_fu_pkg::*;

    MULT_PACKET  mult_packet;
    logic        mult_free;
    logic        cdb_gnt;
    logic        cdb_req;
    DATA         cdb_data;
    PHYS_REG_IDX cdb_dest;

    modport master (
        output mult_packet,
        output cdb_gnt,
        input  mult_free,
        input  cdb_req,
        input  cdb_data,
        input  cdb_dest
    );

    modport slave (
        input  mult_packet,
        input  cdb_gnt,
        output mult_free,
        output cdb_req,
        output cdb_data,
        output cdb_dest
    );
endinterface

// File: rtl/mult_fu_stage.sv
// mult_fu_stage: one pipeline slot. Folds FOLD_W multiplier bits starting at STAGE_IDX*FOLD_W
// into the accumulator and registers the slot when enabled. Slots whose bit range lies above
// the accumulator width (MUL-only build) just pass the op along.
module mult_fu_stage
    import mult_fu_pkg::*;
#(
    parameter int STAGE_IDX = 0,
    parameter int FOLD_W    = 16
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   en,
    input  stage_t prev_slot,
    output stage_t slot
);

    stage_t next_slot;

    if (STAGE_IDX * FOLD_W < ACC_W) begin : g_fold
        localparam int LO     = STAGE_IDX * FOLD_W;
        localparam int SLICE_W = (ACC_W - LO < FOLD_W) ? (ACC_W - LO) : FOLD_W;
        acc_t partial;

        assign partial = (prev_slot.mcand << LO) * acc_t'(prev_slot.mplier[LO +: SLICE_W]);

        // Add this slot's partial product; everything else rides along unchanged.
        always_comb begin
            next_slot     = prev_slot;
            next_slot.acc = prev_slot.acc + partial;
        end
    end else begin : g_pass
        assign next_slot = prev_slot;
    end

    // Slot register: cleared on reset, frozen while the pipe is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot <= '0;
        end else if (en) begin
            slot <= next_slot;
        end
    end

endmodule

// File: rtl/mult_fu.sv
// mult_fu: pipelined integer multiply FU between issue and the CDB arbiter.
// Operand prep feeds slot 0; the last slot's register doubles as the CDB output register.
// Build option MULT_HIGH_EN enables MULH/MULHSU/MULHU; without it only MUL is legal.
module mult_fu
    import mult_fu_pkg::*;
#(
    parameter int NUM_MULT_STAGES = DEFAULT_MULT_STAGES
) (
    input logic      clock,
    input logic      reset,
    mult_fu_if.slave bus
);

    localparam int FOLD_W = 64 / NUM_MULT_STAGES;

    logic   advance;
    stage_t issue_slot;
    stage_t tail;
    stage_t pipe_in  [NUM_MULT_STAGES];
    stage_t pipe_out [NUM_MULT_STAGES];
    logic   unused_tail;

    // A held result blocks the whole pipe; a grant releases it in the same cycle.
    assign advance       = !(tail.valid && !bus.cdb_gnt);
    assign bus.mult_free = advance;

`ifdef MULT_HIGH_EN
    logic sign_1;
    logic sign_2;

    assign sign_1 = (bus.mult_packet.func != MULHU);
    assign sign_2 = (bus.mult_packet.func == MUL) || (bus.mult_packet.func == MULH);
`endif

    // Operand prep: extend both sources to accumulator width according to func.
    always_comb begin
        issue_slot       = '0;
        issue_slot.valid = bus.mult_packet.valid;
        issue_slot.func  = bus.mult_packet.func;
        issue_slot.dest  = bus.mult_packet.dest_reg_idx;
`ifdef MULT_HIGH_EN
        issue_slot.mcand  = {{32{sign_1 & bus.mult_packet.source_reg_1[31]}}, bus.mult_packet.source_reg_1};
        issue_slot.mplier = {{32{sign_2 & bus.mult_packet.source_reg_2[31]}}, bus.mult_packet.source_reg_2};
`else
        issue_slot.mcand  = bus.mult_packet.source_reg_1;
        issue_slot.mplier = bus.mult_packet.source_reg_2;
`endif
    end

    for (genvar k = 0; k < NUM_MULT_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign pipe_in[k] = issue_slot;
        end else begin : g_body
            assign pipe_in[k] = pipe_out[k-1];
        end

        mult_fu_stage #(
            .STAGE_IDX (k),
            .FOLD_W    (FOLD_W)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .en        (advance),
            .prev_slot (pipe_in[k]),
            .slot      (pipe_out[k])
        );
    end

    assign tail         = pipe_out[NUM_MULT_STAGES-1];
    assign bus.cdb_req  = tail.valid;
    assign bus.cdb_dest = tail.dest;

`ifdef MULT_HIGH_EN
    assign bus.cdb_data = (tail.func == MUL) ? tail.acc[31:0] : tail.acc[63:32];
    assign unused_tail  = ^{tail.mcand, tail.mplier};
`else
    assign bus.cdb_data = tail.acc;
    assign unused_tail  = ^{tail.func, tail.mcand, tail.mplier};
`endif

    // Issue protocol checks: no packet while full, and only MUL in the MUL-only build.
    always @(posedge clock) begin
        if (!reset && bus.mult_packet.valid) begin
            assert (advance)
                else $error("mult_fu: packet issued while mult_free=0 was dropped");
`ifndef MULT_HIGH_EN
            assert (bus.mult_packet.func == MUL)
                else $error("mult_fu: non-MUL func issued to MUL-only build");
`endif
        end
    end

endmodule

// File: tb/tb_mult_fu.sv
// tb_mult_fu: directed vectors for mult_fu with a FIFO scoreboard on CDB pops.
module tb_mult_fu;
    import mult_fu_pkg::*;

    typedef struct {
        PHYS_REG_IDX dest;
        DATA         data;
    } exp_t;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [$];

    mult_fu_if bus_if ();

    mult_fu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input PHYS_REG_IDX d, input DATA r);
        exp_t e;
        e.dest = d;
        e.data = r;
        exp_q.push_back(e);
    endtask

    task automatic set_op(input MULT_FUNC f, input DATA a, input DATA b, input PHYS_REG_IDX d);
        bus_if.mult_packet.valid        = 1'b1;
        bus_if.mult_packet.func         = f;
        bus_if.mult_packet.source_reg_1 = a;
        bus_if.mult_packet.source_reg_2 = b;
        bus_if.mult_packet.dest_reg_idx = d;
    endtask

    // Issue one op with its expected result and advance a cycle (stays valid if caller issues again).
    task automatic run_op(input MULT_FUNC f, input DATA a, input DATA b, input PHYS_REG_IDX d, input DATA r);
        push_exp(d, r);
        set_op(f, a, b, d);
        step();
    endtask

    task automatic clear_op();
        bus_if.mult_packet = '0;
    endtask

    // Count cycles from capture until cdb_req, bounded by budget.
    task automatic wait_req(input int budget, output int lat);
        lat = 1;
        forever begin
            @(negedge clock);
            if (bus_if.cdb_req === 1'b1 || lat >= budget) break;
            step();
            lat++;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every granted result must match the oldest outstanding op.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus_if.cdb_req === 1'b1 && bus_if.cdb_gnt === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_out", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_dest", 64'(bus_if.cdb_dest), 64'(e.dest));
                check("sb_data", 64'(bus_if.cdb_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
        $fatal(1, "tb_mult_fu timeout");
    end

    DATA t4_a [4] = '{32'd3, 32'h1234_5678, 32'h0000_FFFF, 32'h7FFF_FFFF};
    DATA t4_b [4] = '{32'd5, 32'h0000_0010, 32'h0000_FFFF, 32'h7FFF_FFFF};
    DATA t4_r [4] = '{32'd15, 32'h2345_6780, 32'hFFFE_0001, 32'h0000_0001};

    initial begin
        int lat;
        int seen;

        reset          = 1'b1;
        bus_if.cdb_gnt = 1'b0;
        clear_op();

        // Reset held two cycles, then released.
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_req", 64'(bus_if.cdb_req), 64'd0);
        check("rst_free", 64'(bus_if.mult_free), 64'd1);
        check("rst_data", 64'(bus_if.cdb_data), 64'd0);
        check("rst_dest", 64'(bus_if.cdb_dest), 64'd0);

        // Single MUL with grant tied high: latency and result.
        step();
        bus_if.cdb_gnt = 1'b1;
        run_op(MUL, 32'd7, 32'hFFFF_FFFD, 6'd12, 32'hFFFF_FFEB);
        clear_op();
        wait_req(12, lat);
        check("t2_latency", 64'(lat), 64'd4);
        check("t2_dest", 64'(bus_if.cdb_dest), 64'd12);
        check("t2_data", 64'(bus_if.cdb_data), 64'hFFFF_FFEB);
        step();
        @(negedge clock);
        check("t2_req_drop", 64'(bus_if.cdb_req), 64'd0);

        // Back-to-back stream of function/operand corners.
        step();
        run_op(MUL, 32'hFFFF_FFFF, 32'd2, 6'd40, 32'hFFFF_FFFE);
        run_op(MUL, 32'h8000_0000, 32'h8000_0000, 6'd41, 32'h0000_0000);
`ifdef MULT_HIGH_EN
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 6'd42, 32'h4000_0000);
        run_op(MULHSU, 32'h8000_0000, 32'h8000_0000, 6'd43, 32'hC000_0000);
        run_op(MULHU,  32'h8000_0000, 32'h8000_0000, 6'd44, 32'h4000_0000);
        run_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd45, 32'h0000_0000);
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd46, 32'hFFFF_FFFF);
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd47, 32'hFFFF_FFFE);
`else
        run_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd42, 32'h0000_0001);
        run_op(MUL, 32'h0001_0001, 32'h0001_0001, 6'd43, 32'h0002_0001);
`endif
        clear_op();
        drain("t3", 20);

        // Four ops into a stalled CDB, then release: FIFO order, one per cycle.
        bus_if.cdb_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_op(MUL, t4_a[k], t4_b[k], PHYS_REG_IDX'(k + 1), t4_r[k]);
        end
        clear_op();
        @(negedge clock);
        check("t4_req_stall", 64'(bus_if.cdb_req), 64'd1);
        check("t4_free_stall", 64'(bus_if.mult_free), 64'd0);
        step();
        step();
        @(negedge clock);
        check("t4_hold_dest", 64'(bus_if.cdb_dest), 64'd1);
        check("t4_hold_free", 64'(bus_if.mult_free), 64'd0);
        step();
        bus_if.cdb_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("t4_pop_req", 64'(bus_if.cdb_req), 64'd1);
            check("t4_pop_dest", 64'(bus_if.cdb_dest), 64'(k + 1));
            step();
        end
        @(negedge clock);
        check("t4_req_after", 64'(bus_if.cdb_req), 64'd0);
        drain("t4", 4);

        // New issue on the very cycle a stalled result is granted.
        step();
        bus_if.cdb_gnt = 1'b0;
        run_op(MUL, 32'd6, 32'd7, 6'd20, 32'd42);
        clear_op();
        wait_req(12, lat);
        check("t5_first_latency", 64'(lat), 64'd4);
        check("t5_free_stall", 64'(bus_if.mult_free), 64'd0);
        step();
        step();
        push_exp(6'd21, 32'h0123_4500);
        set_op(MUL, 32'h0001_2345, 32'h0000_0100, 6'd21);
        bus_if.cdb_gnt = 1'b1;
        #1;
        check("t5_free_on_gnt", 64'(bus_if.mult_free), 64'd1);
        step();
        clear_op();
        wait_req(12, lat);
        check("t5_latency", 64'(lat), 64'd4);
        check("t5_dest", 64'(bus_if.cdb_dest), 64'd21);
        drain("t5", 4);

        // Reset with three ops in flight: none of them may ever reach the CDB.
        step();
        set_op(MUL, 32'd2, 32'd3, 6'd30);
        step();
        set_op(MUL, 32'd4, 32'd5, 6'd31);
        step();
        set_op(MUL, 32'd6, 32'd7, 6'd32);
        step();
        clear_op();
        reset = 1'b1;
        step();
        @(negedge clock);
        check("t6_req_flush", 64'(bus_if.cdb_req), 64'd0);
        check("t6_free", 64'(bus_if.mult_free), 64'd1);
        step();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus_if.cdb_req === 1'b1) seen++;
            step();
        end
        check("t6_no_late_req", 64'(seen), 64'd0);

        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
